// File: rtl/ram_arb_clear.sv
// Single-port block RAM with a hardware clear sweep and an NUM_CH-way round-robin
// request front end. No request is served until every word has been written once.
module ram_arb_clear #(
    parameter int                    ADDR_WIDTH  = 17,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    NUM_CH      = 2,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                           clk_in,
    input  logic                           reset,
    output logic                           ready,
    input  logic                           clear_req,
    input  logic [NUM_CH-1:0]              req_valid,
    output logic [NUM_CH-1:0]              req_ready,
    input  logic [NUM_CH-1:0]              req_we,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_CH-1:0]              resp_valid,
    output logic [NUM_CH*DATA_WIDTH-1:0]   resp_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [NUM_CH-1:0]       resp_valid_q;
    logic [DATA_WIDTH-1:0]   rd_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    serve;
    logic                    gnt_vld;
    logic [PTR_W-1:0]        gnt_idx;
    logic [NUM_CH-1:0]       gnt_onehot;
    logic                    sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    int                      idx;

    assign ready = (state_q == RUN);
    assign serve = (state_q == RUN) && !clear_req && !reset;

    // Round-robin search starting at the pointer, first valid channel wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        if (serve) begin
            for (int k = 0; k < NUM_CH; k++) begin
                idx = (int'(ptr_q) + k) % NUM_CH;
                if (!gnt_vld && req_valid[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = PTR_W'(idx);
                end
            end
        end
    end

    assign gnt_onehot = gnt_vld ? (NUM_CH'(1) << gnt_idx) : '0;
    // A lone channel sees a plain "accepting" level, independent of its own valid.
    assign req_ready  = (NUM_CH == 1) ? {NUM_CH{serve}} : gnt_onehot;

    assign sel_we    = req_we[gnt_idx];
    assign sel_addr  = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q)
                    state_d = RUN;
            end
            RUN: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (gnt_vld) begin
                    ptr_d = (gnt_idx == PTR_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q      <= CLEAR;
            cnt_q        <= '0;
            ptr_q        <= '0;
            resp_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            resp_valid_q <= (gnt_vld && !sel_we) ? gnt_onehot : '0;
        end
    end

    // Array and read register carry no reset; the sweep initialises the array.
    always_ff @(posedge clk_in) begin
        if (!reset && state_q == CLEAR)
            mem[cnt_q] <= CLEAR_VALUE;
        else if (gnt_vld && sel_we)
            mem[sel_addr] <= sel_wdata;
        if (gnt_vld && !sel_we)
            rd_q <= mem[sel_addr];
    end

    assign resp_valid = resp_valid_q;

    always_comb begin
        resp_rdata = '0;
        for (int i = 0; i < NUM_CH; i++)
            resp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = resp_valid_q[i] ? rd_q : '0;
    end

endmodule

// File: tb/tb_ram_arb_clear.sv
// Bench for ram_arb_clear: directed scenarios then random traffic, all checked
// cycle by cycle against a word-array / pointer reference model.
module tb_ram_arb_clear;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic        reset;
    logic        clear_req;
    logic [1:0]  req_valid, req_we;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        ready;
    logic [1:0]  req_ready, resp_valid;
    logic [15:0] resp_rdata;

    logic        c2;
    logic [0:0]  v2, we2, rr2, rv2;
    logic [3:0]  a2;
    logic [31:0] wd2, rd2;
    logic        ready2;

    ram_arb_clear #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .NUM_CH(2), .CLEAR_VALUE(8'hA5)) dut (
        .clk_in(clk_in), .reset(reset), .ready(ready), .clear_req(clear_req),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata));

    ram_arb_clear #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_CH(1), .CLEAR_VALUE(32'h0)) dut2 (
        .clk_in(clk_in), .reset(reset), .ready(ready2), .clear_req(c2),
        .req_valid(v2), .req_ready(rr2), .req_we(we2),
        .req_addr(a2), .req_wdata(wd2),
        .resp_valid(rv2), .resp_rdata(rd2));

    int tests = 0;
    int fails = 0;

    // Reference model: word array, clear progress, round-robin pointer, pending response.
    logic [7:0]  m_mem [16];
    bit          m_clr = 1'b1;
    int          m_cnt = 0;
    int          m_ptr = 0;
    logic [1:0]  e_rv = '0;
    logic [15:0] e_rd = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs mid-cycle, advance the model, then step past the edge.
    task automatic cyc();
        int          g;
        int          id;
        logic [1:0]  e_rr;
        logic [1:0]  n_rv;
        logic [15:0] n_rd;
        logic [3:0]  ad;
        @(negedge clk_in);
        g    = -1;
        e_rr = '0;
        n_rv = '0;
        n_rd = '0;
        if (!reset && !m_clr && !clear_req)
            for (int k = 0; k < 2; k++) begin
                id = (m_ptr + k) % 2;
                if (g < 0 && req_valid[id]) g = id;
            end
        if (g >= 0) e_rr[g] = 1'b1;
        chk("ready", ready, !m_clr);
        chk("req_ready", req_ready, e_rr);
        chk("resp_valid", resp_valid, e_rv);
        chk("resp_rdata", resp_rdata, e_rd);
        if (reset) begin
            m_clr = 1'b1; m_cnt = 0; m_ptr = 0;
        end else if (m_clr) begin
            m_cnt++;
            if (m_cnt == 16) begin
                m_clr = 1'b0;
                for (int a = 0; a < 16; a++) m_mem[a] = 8'hA5;
            end
        end else if (clear_req) begin
            m_clr = 1'b1; m_cnt = 0;
        end else if (g >= 0) begin
            ad = req_addr[g*4 +: 4];
            if (req_we[g]) m_mem[ad] = req_wdata[g*8 +: 8];
            else begin
                n_rv[g] = 1'b1;
                n_rd[g*8 +: 8] = m_mem[ad];
            end
            m_ptr = (g + 1) % 2;
        end
        e_rv = n_rv;
        e_rd = n_rd;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        req_valid = '0; req_we = '0; clear_req = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (ready !== 1'b1 && n < 40) begin
            cyc();
            n++;
        end
        chk(tag, n, 16);
    endtask

    initial begin
        reset = 1'b1; clear_req = 1'b0; req_valid = '0; req_we = '0;
        req_addr = '0; req_wdata = '0;
        c2 = 1'b0; v2 = '0; we2 = '0; a2 = '0; wd2 = '0;
        @(posedge clk_in); #1;
        cyc();
        reset = 1'b0;

        // 1: sweep length and cleared contents
        wait_ready("t1_ready_edges");
        for (int a = 0; a < 16; a++) begin
            req_valid = 2'b01; req_we = 2'b00; req_addr = 8'(a);
            cyc();
            chk("t1_clear_word", resp_rdata[7:0], 8'hA5);
        end
        idle(); cyc();

        // 2: write then immediate read-back on ch0
        req_valid = 2'b01; req_we = 2'b01; req_addr = 8'h03; req_wdata = 16'h005C;
        cyc();
        req_we = 2'b00;
        cyc();
        chk("t2_resp_valid", resp_valid, 2'b01);
        chk("t2_rdata", resp_rdata[7:0], 8'h5C);
        idle(); cyc();

        // 3: both channels reading continuously -> alternate grants
        req_valid = 2'b11; req_we = 2'b00; req_addr = {4'd2, 4'd1};
        cyc();
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("t3_one_resp", 32'($countones(resp_valid)), 1);
        end
        idle(); cyc();

        // 4: write, read just before clear, clear blocks grants, sweep restores A5
        req_valid = 2'b01; req_we = 2'b01; req_addr = 8'h07; req_wdata = 16'h0011;
        cyc();
        req_valid = 2'b10; req_we = 2'b00; req_addr = 8'h70;
        cyc();
        chk("t4_pre_clear_read", resp_rdata[15:8], 8'h11);
        clear_req = 1'b1;
        #1;
        chk("t4_blocked", req_ready, 2'b00);
        cyc();
        idle();
        wait_ready("t4_ready_edges");
        req_valid = 2'b10; req_addr = 8'h70;
        cyc();
        chk("t4_after_clear", resp_rdata[15:8], 8'hA5);
        idle(); cyc();

        // 5: reset during sweep restarts it
        clear_req = 1'b1; cyc(); clear_req = 1'b0;
        repeat (9) cyc();
        reset = 1'b1; cyc(); reset = 1'b0;
        wait_ready("t5_ready_edges");

        // 6: single-channel wide instance
        chk("t6_ready2", ready2, 1'b1);
        chk("t6_rr2_idle", rr2, 1'b1);
        v2 = 1'b1; we2 = 1'b1; a2 = 4'd15; wd2 = 32'hDEADBEEF;
        #1; chk("t6_rr2_wr", rr2, 1'b1);
        cyc();
        we2 = 1'b0;
        cyc();
        chk("t6_rv2", rv2, 1'b1);
        chk("t6_rd15", rd2, 32'hDEADBEEF);
        a2 = 4'd14;
        cyc();
        chk("t6_rd14", rd2, 32'h0);
        v2 = 1'b0;
        cyc();
        chk("t6_rv2_idle", rv2, 1'b0);
        chk("t6_rd2_idle", rd2, 32'h0);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            req_valid = 2'($urandom);
            req_we    = 2'($urandom);
            req_addr  = 8'($urandom);
            req_wdata = 16'($urandom);
            clear_req = ($urandom_range(0, 39) == 0);
            cyc();
        end
        idle(); cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
